// File: rtl/mc_control.sv
// rtl/mc_control.sv - multi-cycle control unit: fetch/decode FSM, register file, memory and ALU sequencing
module mc_control #(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter int              PC_IDX   = 30,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [3:0]      alu_opcode,
    output logic [XLEN-1:0] alu_op1,
    output logic [XLEN-1:0] alu_op2,
    input  logic [XLEN-1:0] alu_out,
    output logic            halted,
    output logic [1:0]      fault_code,
    output logic [31:0]     retired
);
    localparam int IW = $clog2(NREGS);

    typedef enum logic [2:0] {
        FETCH, FETCH_WAIT, DECODE, MEM_WAIT, WRITEBACK, HALT
    } state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] regs [NREGS];
    logic [31:0]     instr;

    logic [5:0]      op;
    logic [2:0]      cond;
    logic [4:0]      ra, rb, rc;
    logic [XLEN-1:0] simm, imm16, jabs, jrel;
    logic [XLEN-1:0] pc, ra_val, rb_val, ld_addr, st_addr;

    assign op    = instr[5:0];
    assign cond  = instr[8:6];
    assign ra    = instr[13:9];
    assign rb    = instr[18:14];
    assign rc    = instr[23:19];
    assign simm  = {{(XLEN-13){instr[31]}}, instr[31:19]};
    assign imm16 = {{(XLEN-16){1'b0}}, instr[31:16]};
    assign jabs  = {{(XLEN-25){1'b0}}, instr[31:9], 2'b00};
    assign jrel  = {{(XLEN-25){instr[31]}}, instr[31:9], 2'b00};

    // Indices beyond the file read as zero.
    assign pc      = regs[IW'(PC_IDX)];
    assign ra_val  = (int'(ra) < NREGS) ? regs[IW'(ra)] : '0;
    assign rb_val  = (int'(rb) < NREGS) ? regs[IW'(rb)] : '0;
    assign ld_addr = ra_val + simm;
    assign st_addr = rb_val + simm;

    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            req_set, req_clr, req_we;
    logic [XLEN-1:0] req_addr, req_wdata;
    logic            instr_we, alu_load, retire, fault_set;
    logic [3:0]      alu_opc_n;
    logic [XLEN-1:0] alu_op2_n;
    logic [1:0]      fault_n;

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        req_set   = 1'b0;
        req_clr   = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        instr_we  = 1'b0;
        alu_load  = 1'b0;
        alu_opc_n = '0;
        alu_op2_n = '0;
        retire    = 1'b0;
        fault_set = 1'b0;
        fault_n   = '0;
        case (state)
            FETCH: begin
                req_set  = 1'b1;
                req_addr = {pc[XLEN-1:2], 2'b00};
                rf_we    = 1'b1;
                rf_waddr = 5'(PC_IDX);
                rf_wdata = pc + XLEN'(4);
                state_n  = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                if (mem_ack) begin
                    instr_we = 1'b1;
                    req_clr  = 1'b1;
                    state_n  = DECODE;
                end
            end
            DECODE: begin
                if (cond != 3'd0) begin
                    retire  = 1'b1;
                    state_n = FETCH;
                end else begin
                    case (op)
                        6'h00: begin
                            retire = 1'b1; state_n = FETCH;
                        end
                        6'h01, 6'h02, 6'h03: begin
                            rf_we    = 1'b1;
                            rf_waddr = 5'(PC_IDX);
                            rf_wdata = (op == 6'h01) ? ra_val : (op == 6'h02) ? jabs : pc + jrel;
                            retire   = 1'b1;
                            state_n  = FETCH;
                        end
                        6'h04: begin
                            rf_we = 1'b1; rf_waddr = rb; rf_wdata = ra_val;
                            retire = 1'b1; state_n = FETCH;
                        end
                        6'h05: begin
                            rf_we    = 1'b1;
                            rf_waddr = ra;
                            if (instr[14]) begin
                                rf_wdata        = ra_val;
                                rf_wdata[31:16] = instr[31:16];
                            end else begin
                                rf_wdata = imm16;
                            end
                            retire  = 1'b1;
                            state_n = FETCH;
                        end
                        6'h06, 6'h08: begin
                            req_addr  = (op == 6'h06) ? ld_addr : st_addr;
                            req_we    = (op == 6'h08);
                            req_wdata = (op == 6'h08) ? ra_val : '0;
                            if (req_addr[1:0] != 2'b00) begin
                                fault_set = 1'b1; fault_n = 2'd2; state_n = HALT;
                            end else begin
                                req_set = 1'b1; state_n = MEM_WAIT;
                            end
                        end
                        6'h10, 6'h11, 6'h13, 6'h14: begin
                            alu_load  = 1'b1;
                            alu_opc_n = (op == 6'h10 || op == 6'h11) ? 4'd1 : 4'd2;
                            alu_op2_n = (op == 6'h10 || op == 6'h13) ? rb_val : simm;
                            state_n   = WRITEBACK;
                        end
                        default: begin
                            fault_set = 1'b1; fault_n = 2'd1; state_n = HALT;
                        end
                    endcase
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    req_clr  = 1'b1;
                    rf_we    = (op == 6'h06);
                    rf_waddr = rb;
                    rf_wdata = mem_rdata;
                    retire   = 1'b1;
                    state_n  = FETCH;
                end
            end
            WRITEBACK: begin
                rf_we    = 1'b1;
                rf_waddr = (op == 6'h10 || op == 6'h13) ? rc : rb;
                rf_wdata = alu_out;
                retire   = 1'b1;
                state_n  = FETCH;
            end
            HALT:    state_n = HALT;
            default: state_n = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= (i == PC_IDX) ? RESET_PC : '0;
            instr      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            alu_opcode <= '0;
            alu_op1    <= '0;
            alu_op2    <= '0;
            halted     <= 1'b0;
            fault_code <= '0;
            retired    <= '0;
        end else begin
            if (rf_we && int'(rf_waddr) < NREGS)
                regs[IW'(rf_waddr)] <= rf_wdata;
            if (req_set) begin
                mem_req   <= 1'b1;
                mem_we    <= req_we;
                mem_addr  <= req_addr;
                mem_wdata <= req_wdata;
            end else if (req_clr) begin
                mem_req <= 1'b0;
            end
            if (instr_we) instr <= mem_rdata[31:0];
            if (alu_load) begin
                alu_opcode <= alu_opc_n;
                alu_op1    <= ra_val;
                alu_op2    <= alu_op2_n;
            end
            if (retire) retired <= retired + 32'd1;
            if (fault_set) begin
                halted     <= 1'b1;
                fault_code <= fault_n;
            end
        end
    end
endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - directed bench for mc_control with a latency-configurable memory and ALU model
module tb_mc_control;
    logic        clk, reset;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_op1, alu_op2, alu_out;
    logic        halted;
    logic [1:0]  fault_code;
    logic [31:0] retired;

    mc_control dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_out(alu_out),
        .halted(halted), .fault_code(fault_code), .retired(retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        alu_out = 32'd0;
        if (alu_opcode == 4'd1)      alu_out = alu_op1 + alu_op2;
        else if (alu_opcode == 4'd2) alu_out = alu_op1 - alu_op2;
    end

    logic [31:0] mem [0:255];
    int          lat;
    int          n_cmp, n_bad;

    // Request log: one entry per request, written only by the monitor.
    logic [31:0] rq_addr [0:2047];
    logic        rq_we   [0:2047];
    logic [31:0] rq_wdata[0:2047];
    logic [31:0] rq_ret  [0:2047];
    int          rq_len  [0:2047];
    logic        rq_stable[0:2047];
    int          rq_n;

    initial begin
        int cnt;
        cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                if (cnt >= lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_we ? 32'd0 : mem[mem_addr[9:2]];
                    cnt       = 0;
                end else begin
                    mem_ack = 1'b0;
                    cnt++;
                end
            end else begin
                mem_ack = 1'b0;
                cnt     = 0;
            end
        end
    end

    initial begin
        logic prev;
        prev = 1'b0;
        rq_n = 0;
        forever begin
            @(posedge clk); #1;
            if (mem_req === 1'b1 && !prev && rq_n < 2047) begin
                rq_addr[rq_n]   = mem_addr;
                rq_we[rq_n]     = mem_we;
                rq_wdata[rq_n]  = mem_wdata;
                rq_ret[rq_n]    = retired;
                rq_len[rq_n]    = 1;
                rq_stable[rq_n] = 1'b1;
                rq_n++;
            end else if (mem_req === 1'b1 && prev && rq_n > 0) begin
                rq_len[rq_n-1]++;
                if (mem_addr !== rq_addr[rq_n-1]) rq_stable[rq_n-1] = 1'b0;
            end
            prev = (mem_req === 1'b1);
        end
    end

    function automatic logic [31:0] enc_movi(input logic [4:0] ra, input logic [15:0] imm, input logic hi);
        return {imm, 1'b0, hi, ra, 3'b000, 6'h05};
    endfunction
    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] ra, rb, rc, input logic [2:0] cond);
        return {8'h00, rc, rb, ra, cond, op};
    endfunction
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] ra, rb, input logic [12:0] simm);
        return {simm, rb, ra, 3'b000, op};
    endfunction
    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [22:0] off);
        return {off, 3'b000, op};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    endtask

    task automatic do_reset(output int base);
        reset = 1'b1;
        @(posedge clk); #2;
        @(posedge clk); #2;
        base  = rq_n;
        reset = 1'b0;
    endtask

    task automatic wait_rq(input int target, input string name, output bit ok);
        int c;
        c = 0;
        while (rq_n < target && c < 600) begin
            @(posedge clk); #2;
            c++;
        end
        ok = (rq_n >= target);
        if (!ok) timeout(name);
    endtask

    task automatic wait_wr(input int from, input string name, output int idx);
        idx = -1;
        for (int c = 0; c < 600 && idx < 0; c++) begin
            for (int k = from; k < rq_n; k++)
                if (rq_we[k] && idx < 0) idx = k;
            if (idx < 0) begin
                @(posedge clk); #2;
            end
        end
        if (idx < 0) timeout(name);
    endtask

    typedef struct packed {
        logic [31:0] s0;
        logic [31:0] s1;
        logic [31:0] ti;
        logic [4:0]  dst;
        logic [31:0] exp;
    } vec_t;

    task automatic run_vec(input int id, input vec_t v);
        int  base, w;
        bit  ok;
        clear_mem();
        mem[0]  = v.s0;
        mem[1]  = v.s1;
        mem[2]  = v.ti;
        mem[3]  = enc_i(6'h08, v.dst, 5'd0, 13'h200);
        mem[66] = 32'hDEADBEEF;
        lat = 0;
        do_reset(base);
        wait_wr(base, $sformatf("v%0d_store", id), w);
        if (w < 1) return;
        check($sformatf("v%0d_fetch12_addr", id), rq_addr[w-1], 32'd12);
        check($sformatf("v%0d_retired3", id), rq_ret[w-1], 32'd3);
        check($sformatf("v%0d_st_addr", id), rq_addr[w], 32'h200);
        check($sformatf("v%0d_result", id), rq_wdata[w], v.exp);
        wait_rq(w + 2, $sformatf("v%0d_next", id), ok);
        if (ok) begin
            check($sformatf("v%0d_fetch16_addr", id), rq_addr[w+1], 32'd16);
            check($sformatf("v%0d_retired4", id), rq_ret[w+1], 32'd4);
        end
    endtask

    initial begin
        vec_t vt[11];
        int   base, w;
        bit   ok;
        logic [31:0] jseq[5];

        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        lat   = 0;
        clear_mem();

        vt[0]  = '{enc_movi(5'd4, 16'h0100, 1'b0), 32'd0, enc_i(6'h06, 5'd4, 5'd5, 13'd8), 5'd5, 32'hDEADBEEF};
        vt[1]  = '{enc_movi(5'd1, 16'h1234, 1'b0), enc_movi(5'd2, 16'h0010, 1'b0), enc_r(6'h10, 5'd1, 5'd2, 5'd3, 3'd0), 5'd3, 32'h00001244};
        vt[2]  = '{enc_movi(5'd1, 16'h1234, 1'b0), 32'd0, enc_i(6'h11, 5'd1, 5'd4, 13'h1FFF), 5'd4, 32'h00001233};
        vt[3]  = '{enc_movi(5'd1, 16'h1234, 1'b0), 32'd0, enc_i(6'h14, 5'd1, 5'd4, 13'd5), 5'd4, 32'h0000122F};
        vt[4]  = '{enc_movi(5'd1, 16'hFFFF, 1'b1), 32'd0, enc_r(6'h10, 5'd1, 5'd1, 5'd3, 3'd0), 5'd3, 32'hFFFE0000};
        vt[5]  = '{enc_movi(5'd1, 16'hBEEF, 1'b0), 32'd0, enc_r(6'h04, 5'd1, 5'd5, 5'd0, 3'd0), 5'd5, 32'h0000BEEF};
        vt[6]  = '{enc_movi(5'd1, 16'h1234, 1'b0), 32'd0, enc_movi(5'd1, 16'hABCD, 1'b1), 5'd1, 32'hABCD1234};
        vt[7]  = '{enc_movi(5'd1, 16'hABCD, 1'b1), 32'd0, enc_movi(5'd1, 16'h5678, 1'b0), 5'd1, 32'h00005678};
        vt[8]  = '{enc_movi(5'd1, 16'h1234, 1'b0), enc_movi(5'd2, 16'h0010, 1'b0), enc_r(6'h10, 5'd1, 5'd2, 5'd3, 3'd1), 5'd3, 32'h00000000};
        vt[9]  = '{enc_movi(5'd1, 16'h1234, 1'b0), 32'd0, 32'h000000BF, 5'd1, 32'h00001234};
        vt[10] = '{enc_movi(5'd1, 16'h1234, 1'b0), enc_movi(5'd2, 16'h0010, 1'b0), enc_r(6'h13, 5'd2, 5'd1, 5'd3, 3'd0), 5'd3, 32'hFFFFEDDC};

        for (int i = 0; i < 11; i++) run_vec(i, vt[i]);

        // Reset values after a run that left the outputs non-zero.
        reset = 1'b1;
        @(posedge clk); #2;
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_alu_opcode", {28'd0, alu_opcode}, 32'd0);
        check("rst_alu_op1", alu_op1, 32'd0);
        check("rst_alu_op2", alu_op2, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_fault", {30'd0, fault_code}, 32'd0);
        check("rst_retired", retired, 32'd0);

        // Slow memory: every access acked after 3 wait cycles.
        clear_mem();
        mem[0]  = enc_movi(5'd4, 16'h0100, 1'b0);
        mem[1]  = enc_i(6'h06, 5'd4, 5'd5, 13'd8);
        mem[2]  = enc_i(6'h08, 5'd5, 5'd0, 13'h200);
        mem[66] = 32'hDEADBEEF;
        lat = 3;
        do_reset(base);
        wait_wr(base, "slow_store", w);
        if (w >= 2) begin
            check("slow_fetch_len", rq_len[base], 32'd4);
            check("slow_ld_addr", rq_addr[w-2], 32'h108);
            check("slow_ld_len", rq_len[w-2], 32'd4);
            check("slow_ld_stable", {31'd0, rq_stable[w-2]}, 32'd1);
            check("slow_r5", rq_wdata[w], 32'hDEADBEEF);
        end

        // Reset in the ack cycle of a pending load.
        do_reset(base);
        wait_rq(base + 3, "rstack_load", ok);
        if (ok) begin
            check("rstack_ld_addr", rq_addr[base+2], 32'h108);
            repeat (3) @(posedge clk);
            #2;
            reset  = 1'b1;
            mem[0] = enc_i(6'h08, 5'd5, 5'd0, 13'h200);
            @(posedge clk); #2;
            check("rstack_req", {31'd0, mem_req}, 32'd0);
            check("rstack_retired", retired, 32'd0);
            reset = 1'b0;
            base  = rq_n;
            wait_wr(base, "rstack_store", w);
            if (w >= 1) begin
                check("rstack_refetch", rq_addr[w-1], 32'd0);
                check("rstack_r5", rq_wdata[w], 32'd0);
            end
        end

        // Relative self-loop at 0x20.
        clear_mem();
        mem[8] = enc_j(6'h03, 23'h7FFFFF);
        lat = 1;
        do_reset(base);
        wait_rq(base + 11, "loop", ok);
        if (ok) begin
            for (int k = 8; k < 11; k++) begin
                check($sformatf("loop_addr%0d", k), rq_addr[base+k], 32'h20);
                check($sformatf("loop_ret%0d", k), rq_ret[base+k], k);
            end
        end

        // Absolute jump, immediate and ALU writes to the PC, register jump.
        clear_mem();
        mem[0]  = enc_j(6'h02, 23'h10);
        mem[16] = enc_movi(5'd30, 16'h0080, 1'b0);
        mem[32] = enc_i(6'h11, 5'd0, 5'd30, 13'd12);
        mem[3]  = enc_r(6'h01, 5'd7, 5'd0, 5'd0, 3'd0);
        jseq    = '{32'h0, 32'h40, 32'h80, 32'h0C, 32'h0};
        lat = 0;
        do_reset(base);
        wait_rq(base + 5, "jump", ok);
        if (ok) begin
            for (int k = 0; k < 5; k++)
                check($sformatf("jump_addr%0d", k), rq_addr[base+k], jseq[k]);
            check("jump_ret", rq_ret[base+4], 32'd4);
        end

        // Misaligned store.
        clear_mem();
        mem[0] = enc_movi(5'd2, 16'h0100, 1'b0);
        mem[1] = enc_movi(5'd1, 16'h0055, 1'b0);
        mem[2] = enc_i(6'h08, 5'd1, 5'd2, 13'd2);
        do_reset(base);
        repeat (40) @(posedge clk);
        #2;
        check("mis_halted", {31'd0, halted}, 32'd1);
        check("mis_fault", {30'd0, fault_code}, 32'd2);
        check("mis_req", {31'd0, mem_req}, 32'd0);
        check("mis_retired", retired, 32'd2);
        check("mis_reqs", rq_n - base, 32'd3);

        // Illegal opcode, then recovery by reset.
        clear_mem();
        mem[1] = 32'h0000003F;
        do_reset(base);
        repeat (40) @(posedge clk);
        #2;
        check("ill_halted", {31'd0, halted}, 32'd1);
        check("ill_fault", {30'd0, fault_code}, 32'd1);
        check("ill_retired", retired, 32'd1);
        check("ill_reqs", rq_n - base, 32'd2);
        mem[1] = 32'd0;
        reset = 1'b1;
        @(posedge clk); #2;
        check("ill_rst_halted", {31'd0, halted}, 32'd0);
        check("ill_rst_fault", {30'd0, fault_code}, 32'd0);
        reset = 1'b0;
        base  = rq_n;
        wait_rq(base + 2, "ill_restart", ok);
        if (ok) begin
            check("ill_restart_addr0", rq_addr[base], 32'd0);
            check("ill_restart_addr1", rq_addr[base+1], 32'd4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
